// File: rtl/exu_cdb_arb.sv
// Result-broadcast stage: per-source write-back FIFOs, round-robin arbitration onto NUM_PORT registered CDB ports.
// Optional EXU_CDB_BYPASS_EN: an empty FIFO's incoming result may be granted the same cycle (1-cycle latency).
module exu_cdb_arb #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned NUM_PORT   = 2,
  parameter int unsigned PREG_W     = 6,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_clk,
  input  logic                         rtu_global_flush,
  input  logic [NUM_SRC-1:0]           x_src_vld,
  input  logic [NUM_SRC*PREG_W-1:0]    x_src_preg,
  input  logic [NUM_SRC*DATA_W-1:0]    x_src_result,
  output logic [NUM_SRC-1:0]           x_src_rdy,
  output logic [NUM_PORT-1:0]          exu_idu_cdb_vld,
  output logic [NUM_PORT*PREG_W-1:0]   exu_idu_cdb_preg,
  output logic [NUM_PORT*DATA_W-1:0]   exu_idu_cdb_result
);
  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] result;
  } entry_t;

  entry_t           mem      [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] wptr     [NUM_SRC];
  logic [PTR_W-1:0] rptr     [NUM_SRC];
  logic [CNT_W-1:0] cnt      [NUM_SRC];
  logic [SRC_W-1:0] rr_ptr;

  entry_t           in_entry   [NUM_SRC];
  entry_t           port_entry [NUM_PORT];
  logic [SRC_W-1:0] port_src   [NUM_PORT];
  logic [NUM_PORT-1:0] port_vld;
  logic [NUM_SRC-1:0]  empty, full, push, cand, gnt, wr, pop;
  logic                any_gnt;
  logic [SRC_W-1:0]    last_src;

  // FIFO status and acceptance; rdy looks only at registered counts
  always_comb begin
    empty     = '0;
    full      = '0;
    x_src_rdy = '0;
    push      = '0;
    cand      = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      empty[i]     = (cnt[i] == '0);
      full[i]      = (cnt[i] == CNT_W'(FIFO_DEPTH));
      x_src_rdy[i] = !full[i] && !rtu_global_flush;
      push[i]      = x_src_vld[i] && x_src_rdy[i];
      in_entry[i]  = '{preg: x_src_preg[i*PREG_W +: PREG_W], result: x_src_result[i*DATA_W +: DATA_W]};
`ifdef EXU_CDB_BYPASS_EN
      cand[i]      = !empty[i] || push[i];
`else
      cand[i]      = !empty[i];
`endif
    end
  end

  // Round-robin scan from rr_ptr; k-th candidate found goes to port k
  always_comb begin
    int unsigned n;
    int unsigned idx;
    n        = 0;
    idx      = 0;
    gnt      = '0;
    port_vld = '0;
    any_gnt  = 1'b0;
    last_src = rr_ptr;
    for (int k = 0; k < NUM_PORT; k++) port_src[k] = '0;
    for (int unsigned o = 0; o < NUM_SRC; o++) begin
      idx = 32'(rr_ptr) + o;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (cand[idx] && (n < NUM_PORT)) begin
        gnt[idx]      = 1'b1;
        port_src[n]   = SRC_W'(idx);
        port_vld[n]   = 1'b1;
        last_src      = SRC_W'(idx);
        any_gnt       = 1'b1;
        n             = n + 1;
      end
    end
  end

  // A granted empty source (bypass only) is served straight from its input, not written
  always_comb begin
    pop = '0;
    wr  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = gnt[i] && !empty[i];
      wr[i]  = push[i] && !(gnt[i] && empty[i]);
    end
    for (int k = 0; k < NUM_PORT; k++) begin
      port_entry[k] = '0;
      if (port_vld[k]) begin
        if (empty[port_src[k]]) port_entry[k] = in_entry[port_src[k]];
        else                    port_entry[k] = mem[port_src[k]][rptr[port_src[k]]];
      end
    end
  end

  // FIFO storage carries no reset; validity is tracked by cnt
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (wr[i]) mem[i][wptr[i]] <= in_entry[i];
    end
  end

  always_ff @(posedge clk or negedge rst_clk) begin
    if (!rst_clk) begin
      rr_ptr             <= '0;
      exu_idu_cdb_vld    <= '0;
      exu_idu_cdb_preg   <= '0;
      exu_idu_cdb_result <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else if (rtu_global_flush) begin
      rr_ptr             <= '0;
      exu_idu_cdb_vld    <= '0;
      exu_idu_cdb_preg   <= '0;
      exu_idu_cdb_result <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      if (any_gnt) rr_ptr <= (last_src == SRC_W'(NUM_SRC - 1)) ? '0 : last_src + SRC_W'(1);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (wr[i])  wptr[i] <= wptr[i] + PTR_W'(1);
        if (pop[i]) rptr[i] <= rptr[i] + PTR_W'(1);
        cnt[i] <= cnt[i] + CNT_W'(wr[i]) - CNT_W'(pop[i]);
      end
      for (int k = 0; k < NUM_PORT; k++) begin
        exu_idu_cdb_vld[k]                    <= port_vld[k];
        exu_idu_cdb_preg[k*PREG_W +: PREG_W]   <= port_entry[k].preg;
        exu_idu_cdb_result[k*DATA_W +: DATA_W] <= port_entry[k].result;
      end
    end
  end

endmodule

// File: tb/tb_exu_cdb_arb.sv
// Scoreboard bench for exu_cdb_arb: queue-based reference model predicts every CDB cycle and every rdy vector.
// Honors EXU_CDB_BYPASS_EN the same way as the design build.
module tb_exu_cdb_arb;
  localparam int NS  = 4;
  localparam int NP  = 2;
  localparam int PW  = 6;
  localparam int DW  = 64;
  localparam int DEP = 2;

  logic              clk = 1'b0;
  logic              rst_clk;
  logic              flush;
  logic [NS-1:0]     vld;
  logic [NS*PW-1:0]  preg;
  logic [NS*DW-1:0]  res;
  logic [NS-1:0]     rdy;
  logic [NP-1:0]     cdb_vld;
  logic [NP*PW-1:0]  cdb_preg;
  logic [NP*DW-1:0]  cdb_res;

  exu_cdb_arb #(.NUM_SRC(NS), .NUM_PORT(NP), .PREG_W(PW), .DATA_W(DW), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .rst_clk(rst_clk), .rtu_global_flush(flush),
    .x_src_vld(vld), .x_src_preg(preg), .x_src_result(res), .x_src_rdy(rdy),
    .exu_idu_cdb_vld(cdb_vld), .exu_idu_cdb_preg(cdb_preg), .exu_idu_cdb_result(cdb_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              stamp;
    logic [NP-1:0]   vld;
    logic [NP*PW-1:0] preg;
    logic [NP*DW-1:0] res;
  } rec_t;

  rec_t              sb[$];
  logic [PW+DW-1:0]  mq[NS][$];
  int                rr = 0;
  int                edges = 0;
  int                errors = 0;
  int                checks = 0;
  rec_t              mon_e;

  always @(posedge clk) edges <= edges + 1;

  // Monitor: every CDB beat (or an overdue expectation) consumes one scoreboard record
  always @(posedge clk) begin
    #1;
    if (rst_clk && ((|cdb_vld) || (sb.size() > 0 && sb[0].stamp <= edges))) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected edge=%0d got vld=%b preg=%h res=%h, required no output", edges, cdb_vld, cdb_preg, cdb_res);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.stamp != edges || mon_e.vld !== cdb_vld || mon_e.preg !== cdb_preg || mon_e.res !== cdb_res) begin
          errors++;
          $display("FAIL cdb_beat edge=%0d got vld=%b preg=%h res=%h, required edge=%0d vld=%b preg=%h res=%h",
                   edges, cdb_vld, cdb_preg, cdb_res, mon_e.stamp, mon_e.vld, mon_e.preg, mon_e.res);
        end
      end
    end
  end

  // Reference model for the coming edge, evaluated with the inputs now applied
  task automatic model_step();
    logic [NS-1:0] er, psh, byp;
    rec_t e;
    int n, idx, last;
    bit any, g;
    logic [PW+DW-1:0] ent;
    er = '0; psh = '0; byp = '0;
    for (int i = 0; i < NS; i++) er[i] = (mq[i].size() < DEP) && !flush;
    checks++;
    if (rdy !== er) begin
      errors++;
      $display("FAIL src_rdy edge=%0d got %b, required %b", edges, rdy, er);
    end
    if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      rr = 0;
      return;
    end
    for (int i = 0; i < NS; i++) psh[i] = vld[i] && er[i];
    e.stamp = edges + 1; e.vld = '0; e.preg = '0; e.res = '0;
    n = 0; any = 0; last = rr;
    for (int o = 0; o < NS; o++) begin
      idx = (rr + o) % NS;
      g = 0;
      ent = '0;
      if (n < NP) begin
        if (mq[idx].size() > 0) begin
          ent = mq[idx].pop_front();
          g = 1;
        end
`ifdef EXU_CDB_BYPASS_EN
        else if (psh[idx]) begin
          ent = {preg[idx*PW +: PW], res[idx*DW +: DW]};
          byp[idx] = 1'b1;
          g = 1;
        end
`endif
      end
      if (g) begin
        e.vld[n] = 1'b1;
        e.preg[n*PW +: PW] = ent[PW+DW-1:DW];
        e.res[n*DW +: DW]  = ent[DW-1:0];
        n++;
        any = 1;
        last = idx;
      end
    end
    for (int i = 0; i < NS; i++)
      if (psh[i] && !byp[i]) mq[i].push_back({preg[i*PW +: PW], res[i*DW +: DW]});
    if (any) begin
      rr = (last + 1) % NS;
      sb.push_back(e);
    end
  endtask

  task automatic drive(input logic [NS-1:0] v, input bit fl);
    @(negedge clk);
    vld = v;
    flush = fl;
    for (int i = 0; i < NS; i++) begin
      preg[i*PW +: PW] = PW'($urandom);
      res[i*DW +: DW]  = {$urandom, $urandom};
    end
    #1 model_step();
  endtask

  initial begin
    rst_clk = 1'b0; flush = 1'b0; vld = '0; preg = '0; res = '0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (cdb_vld !== '0 || cdb_preg !== '0 || cdb_res !== '0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b preg=%h res=%h, required all 0", cdb_vld, cdb_preg, cdb_res);
    end
    @(negedge clk);
    rst_clk = 1'b1;
    #1;
    checks++;
    if (rdy !== '1) begin
      errors++;
      $display("FAIL reset_rdy got %b, required %b", rdy, {NS{1'b1}});
    end

    // single result from source 0
    @(negedge clk);
    vld = 4'b0001; flush = 1'b0;
    preg[PW-1:0] = 6'd5;
    res[DW-1:0]  = 64'h1234;
    #1 model_step();
    repeat (4) drive('0, 1'b0);

    // all sources streaming, then drain
    repeat (8) drive(4'hF, 1'b0);
    repeat (6) drive('0, 1'b0);

    // fill everything, flush with inputs present
    repeat (4) drive(4'hF, 1'b0);
    drive(4'hF, 1'b1);
    repeat (4) drive('0, 1'b0);

    // lone source 2
    repeat (6) drive(4'b0100, 1'b0);
    repeat (3) drive('0, 1'b0);

    // asynchronous reset between edges with ports busy
    repeat (3) drive(4'hF, 1'b0);
    @(posedge clk);
    #3;
    rst_clk = 1'b0;
    vld = '0;
    #1;
    checks++;
    if (cdb_vld !== '0 || cdb_preg !== '0 || cdb_res !== '0) begin
      errors++;
      $display("FAIL async_reset got vld=%b preg=%h res=%h, required all 0", cdb_vld, cdb_preg, cdb_res);
    end
    sb.delete();
    for (int i = 0; i < NS; i++) mq[i].delete();
    rr = 0;
    @(negedge clk);
    rst_clk = 1'b1;

    // random traffic with occasional flush
    repeat (300) drive(NS'($urandom), ($urandom_range(0, 31) == 0));
    repeat (8) drive('0, 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending results, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
